// File: rtl/dac_sample_player.sv
// Streams FIFO'd sample bytes to the SpecDrum/Covox/Soundrive DAC ports as Z80-style I/O writes.
// Optional macro SAMPLE_PLAYER_SILENCE_EN: an underrun tick writes mid-scale 0x80 instead of skipping.
module dac_sample_player #(
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   period,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic [15:0]        a,
  output logic [7:0]         d,
  output logic               iorq_n,
  output logic               wr_n,
  output logic [FIFO_AW:0]   level,
  output logic               underrun
);

  localparam int DEPTH_I = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(DEPTH_I);

  typedef enum logic [2:0] {IDLE, REQ, SETUP, STROBE, HOLD} state_t;

  logic [7:0]         mem [0:DEPTH_I-1];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level_n, need;
  logic               push, pop;

  logic [DIV_W-1:0]   div_cnt, period_eff;
  logic               tick;

  state_t      state, state_n;
  logic        pending, pending_n, silent, silent_n, second, second_n, held, held_n;
  logic [1:0]  lat_mode, lat_mode_n;
  logic [7:0]  hold_data, hold_data_n, wbyte, port;
  logic        bus_req_n, iorq_n_n, wr_n_n, set_underrun, load, load_second;
  logic [15:0] a_n;
  logic [7:0]  d_n;

  assign push       = s_valid && s_ready;
  assign need       = (mode == 2'd2) ? (FIFO_AW+1)'(2) : (FIFO_AW+1)'(1);
  assign period_eff = (period == '0) ? DIV_W'(1) : period;
  // >= rather than == so a period shrunk below the running count still ticks promptly
  assign tick       = enable && (div_cnt >= period_eff);

  always_comb begin
    case ({push, pop})
      2'b10:   level_n = level + (FIFO_AW+1)'(1);
      2'b01:   level_n = level - (FIFO_AW+1)'(1);
      default: level_n = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      s_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      level   <= level_n;
      s_ready <= (level_n != DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable || tick) div_cnt <= '0;
    else                        div_cnt <= div_cnt + DIV_W'(1);
  end

  always_comb begin
    state_n      = state;
    pending_n    = pending;
    lat_mode_n   = lat_mode;
    silent_n     = silent;
    second_n     = second;
    held_n       = held;
    hold_data_n  = hold_data;
    bus_req_n    = bus_req;
    iorq_n_n     = 1'b1;
    wr_n_n       = 1'b1;
    a_n          = a;
    d_n          = d;
    pop          = 1'b0;
    set_underrun = 1'b0;
    load         = 1'b0;
    load_second  = second;
    wbyte        = 8'h00;
    port         = 8'hDF;
    case (state)
      IDLE: begin
        bus_req_n = 1'b0;
        pending_n = 1'b0;
        if (enable && (tick || pending)) begin
          lat_mode_n = mode;
          second_n   = 1'b0;
          held_n     = 1'b0;
          if (level < need) begin
            set_underrun = 1'b1;
`ifdef SAMPLE_PLAYER_SILENCE_EN
            silent_n  = 1'b1;
            state_n   = REQ;
            bus_req_n = 1'b1;
`endif
          end else begin
            silent_n  = 1'b0;
            state_n   = REQ;
            bus_req_n = 1'b1;
          end
        end
      end
      REQ: begin
        if (!enable) begin
          state_n   = IDLE;
          bus_req_n = 1'b0;
          held_n    = 1'b0;
        end else if (bus_gnt) begin
          state_n = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        if (!enable) begin
          state_n   = IDLE;
          bus_req_n = 1'b0;
          held_n    = 1'b0;
        end else if (!bus_gnt) begin
          state_n = REQ;
        end else begin
          state_n  = STROBE;
          iorq_n_n = 1'b0;
          wr_n_n   = 1'b0;
          held_n   = 1'b0;
        end
      end
      STROBE: state_n = HOLD;
      HOLD: begin
        if (enable && lat_mode == 2'd2 && !second) begin
          state_n     = SETUP;
          second_n    = 1'b1;
          load_second = 1'b1;
          load        = 1'b1;
        end else begin
          state_n   = IDLE;
          bus_req_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && tick) pending_n = 1'b1;
    if (!enable)               pending_n = 1'b0;

    // A byte regranted after a lost grant comes from the holding register, never the FIFO again
    if (load) begin
      if (held)        wbyte = hold_data;
      else if (silent) wbyte = 8'h80;
      else begin
        wbyte = mem[rd_ptr];
        pop   = 1'b1;
      end
      case (lat_mode)
        2'd1:    port = 8'hFB;
        2'd2:    port = load_second ? 8'h4F : 8'h0F;
        default: port = 8'hDF;
      endcase
      held_n      = 1'b1;
      hold_data_n = wbyte;
      d_n         = wbyte;
      a_n         = {8'h00, port};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      lat_mode  <= 2'd0;
      silent    <= 1'b0;
      second    <= 1'b0;
      held      <= 1'b0;
      hold_data <= '0;
      bus_req   <= 1'b0;
      iorq_n    <= 1'b1;
      wr_n      <= 1'b1;
      a         <= '0;
      d         <= '0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      lat_mode  <= lat_mode_n;
      silent    <= silent_n;
      second    <= second_n;
      held      <= held_n;
      hold_data <= hold_data_n;
      bus_req   <= bus_req_n;
      iorq_n    <= iorq_n_n;
      wr_n      <= wr_n_n;
      a         <= a_n;
      d         <= d_n;
      if (!enable)           underrun <= 1'b0;
      else if (set_underrun) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dac_sample_player.sv
// Scoreboard bench for dac_sample_player: expected port writes are queued as bytes are pushed.
module tb_dac_sample_player;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, s_ready, bus_req, bus_gnt, iorq_n, wr_n, underrun;
  logic [1:0]  mode;
  logic [15:0] period, a;
  logic [7:0]  s_data, d;
  logic [4:0]  level;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t  exp_q[$];
  int   strobe_cyc[$];
  int   strobe_lvl[$];
  wr_t  e;
  int   tests_run = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prev_strobe = 1'b0;

  dac_sample_player #(.FIFO_AW(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .period(period),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .a(a), .d(d),
    .iorq_n(iorq_n), .wr_n(wr_n), .level(level), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe must match the next queued expectation and last one cycle
  always @(negedge clk) begin
    if (!iorq_n || !wr_n) begin
      tests_run++;
      if (prev_strobe) begin
        fails++;
        $display("FAIL strobe_width: strobe low on consecutive cycles at cycle %0d (required single cycle)", cyc);
      end
      tests_run++;
      if (iorq_n !== 1'b0 || wr_n !== 1'b0) begin
        fails++;
        $display("FAIL strobe_pair: iorq_n=%b wr_n=%b, required both 0", iorq_n, wr_n);
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: a=%h d=%h, required no write", a, d);
      end else begin
        e = exp_q.pop_front();
        if (a !== e.a || d !== e.d) begin
          fails++;
          $display("FAIL write_data: a=%h d=%h, required a=%h d=%h", a, d, e.a, e.d);
        end
      end
      strobe_cyc.push_back(cyc);
      strobe_lvl.push_back(int'(level));
    end
    prev_strobe = !iorq_n || !wr_n;
  end

  task automatic push_byte(input logic [7:0] b, input logic [15:0] ea, input bit expect_wr);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = b;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests_run++;
      fails++;
      $display("FAIL push_timeout: s_ready=%b, required 1 within budget", s_ready);
    end else if (expect_wr) begin
      exp_q.push_back('{ea, b});
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic stop_play();
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    strobe_cyc.delete();
    strobe_lvl.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; mode = 2'd0; period = 16'd99;
    s_valid = 1'b0; s_data = 8'h00; bus_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus_req !== 1'b0 || iorq_n !== 1'b1 || wr_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_ctrl: bus_req=%b iorq_n=%b wr_n=%b, required 0 1 1", bus_req, iorq_n, wr_n);
    end
    tests_run++;
    if (a !== 16'h0000 || d !== 8'h00) begin
      fails++;
      $display("FAIL reset_bus: a=%h d=%h, required 0000 00", a, d);
    end
    tests_run++;
    if (level !== 5'd0 || underrun !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_fifo: level=%0d underrun=%b s_ready=%b, required 0 0 1", level, underrun, s_ready);
    end
  endtask

  task automatic test_mono();
    mode = 2'd0; period = 16'd99; bus_gnt = 1'b1;
    push_byte(8'h12, 16'h00DF, 1'b1);
    push_byte(8'h34, 16'h00DF, 1'b1);
    @(posedge clk); #1 enable = 1'b1;
    wait_drain(400, "mono");
    tests_run++;
    if (strobe_cyc.size() != 2) begin
      fails++;
      $display("FAIL mono_count: %0d strobes, required 2", strobe_cyc.size());
    end else begin
      tests_run++;
      if (strobe_cyc[1] - strobe_cyc[0] != 100) begin
        fails++;
        $display("FAIL mono_spacing: %0d cycles, required 100", strobe_cyc[1] - strobe_cyc[0]);
      end
    end
    stop_play();
  endtask

  task automatic test_stereo();
    mode = 2'd2; period = 16'd20; bus_gnt = 1'b1;
    push_byte(8'hA0, 16'h000F, 1'b1);
    push_byte(8'h5B, 16'h004F, 1'b1);
    @(negedge clk);
    tests_run++;
    if (level !== 5'd2) begin
      fails++;
      $display("FAIL stereo_level_pre: level=%0d, required 2", level);
    end
    @(posedge clk); #1 enable = 1'b1;
    wait_drain(100, "stereo");
    tests_run++;
    if (strobe_cyc.size() != 2) begin
      fails++;
      $display("FAIL stereo_count: %0d strobes, required 2", strobe_cyc.size());
    end else begin
      tests_run++;
      if (strobe_cyc[1] - strobe_cyc[0] != 3) begin
        fails++;
        $display("FAIL stereo_gap: strobes %0d apart, required 3", strobe_cyc[1] - strobe_cyc[0]);
      end
      tests_run++;
      if (strobe_lvl[0] != 1 || strobe_lvl[1] != 0) begin
        fails++;
        $display("FAIL stereo_level: %0d then %0d, required 1 then 0", strobe_lvl[0], strobe_lvl[1]);
      end
    end
    stop_play();
  endtask

  task automatic test_grant();
    bit seen;
    mode = 2'd0; period = 16'd200; bus_gnt = 1'b0;
    push_byte(8'h77, 16'h00DF, 1'b1);
    @(posedge clk); #1 enable = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus_req) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      fails++;
      $display("FAIL grant_req: bus_req=%b, required 1 within budget", bus_req);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (strobe_cyc.size() != 0 || bus_req !== 1'b1 || level !== 5'd1) begin
      fails++;
      $display("FAIL grant_wait: strobes=%0d bus_req=%b level=%0d, required 0 1 1", strobe_cyc.size(), bus_req, level);
    end
    @(posedge clk); #1 bus_gnt = 1'b1;
    @(posedge clk); #1 bus_gnt = 1'b0;
    @(negedge clk);
    tests_run++;
    if (level !== 5'd0 || d !== 8'h77 || a !== 16'h00DF) begin
      fails++;
      $display("FAIL grant_setup: level=%0d a=%h d=%h, required 0 00df 77", level, a, d);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (level !== 5'd0 || iorq_n !== 1'b1 || bus_req !== 1'b1) begin
      fails++;
      $display("FAIL grant_lost: level=%0d iorq_n=%b bus_req=%b, required 0 1 1", level, iorq_n, bus_req);
    end
    @(posedge clk); #1 bus_gnt = 1'b1;
    wait_drain(20, "grant");
    repeat (3) @(negedge clk);
    tests_run++;
    if (strobe_cyc.size() != 1 || level !== 5'd0 || bus_req !== 1'b0) begin
      fails++;
      $display("FAIL grant_once: strobes=%0d level=%0d bus_req=%b, required 1 0 0", strobe_cyc.size(), level, bus_req);
    end
    stop_play();
  endtask

  task automatic test_underrun();
    mode = 2'd0; period = 16'd30; bus_gnt = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
`ifdef SAMPLE_PLAYER_SILENCE_EN
    exp_q.push_back('{16'h00DF, 8'h80});
    wait_drain(100, "silence");
`else
    begin
      bit req_seen;
      req_seen = 1'b0;
      for (int n = 0; n < 45; n++) begin
        @(negedge clk);
        if (bus_req) req_seen = 1'b1;
      end
      tests_run++;
      if (req_seen) begin
        fails++;
        $display("FAIL skip_req: bus_req rose, required no request");
      end
    end
`endif
    tests_run++;
    if (underrun !== 1'b1 || level !== 5'd0) begin
      fails++;
      $display("FAIL underrun_set: underrun=%b level=%0d, required 1 0", underrun, level);
    end
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (underrun !== 1'b0) begin
      fails++;
      $display("FAIL underrun_clear: underrun=%b, required 0", underrun);
    end
    stop_play();
  endtask

  task automatic test_full();
    mode = 2'd0; period = 16'd7; bus_gnt = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i), 16'h00DF, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 8'h99;
    repeat (5) @(negedge clk);
    tests_run++;
    if (level !== 5'd16 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_block: level=%0d s_ready=%b, required 16 0", level, s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    enable  = 1'b1;
    push_byte(8'h99, 16'h00DF, 1'b1);
    @(negedge clk);
    tests_run++;
    if (level !== 5'd16) begin
      fails++;
      $display("FAIL full_refill: level=%0d, required 16", level);
    end
    wait_drain(400, "full");
    @(negedge clk);
    tests_run++;
    if (level !== 5'd0 || strobe_cyc.size() != 17) begin
      fails++;
      $display("FAIL full_drain: level=%0d strobes=%0d, required 0 17", level, strobe_cyc.size());
    end
    stop_play();
  endtask

  task automatic test_reset_mid_strobe();
    bit hit;
    mode = 2'd0; period = 16'd20; bus_gnt = 1'b1;
    push_byte(8'h55, 16'h00DF, 1'b1);
    push_byte(8'h66, 16'h00DF, 1'b0);
    @(posedge clk); #1 enable = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!iorq_n) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!hit) begin
      fails++;
      $display("FAIL rststb_strobe: no strobe within budget, required one");
    end
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (iorq_n !== 1'b1 || wr_n !== 1'b1 || bus_req !== 1'b0 || level !== 5'd0 || a !== 16'h0000) begin
      fails++;
      $display("FAIL rststb_state: iorq_n=%b wr_n=%b bus_req=%b level=%0d a=%h, required 1 1 0 0 0000",
               iorq_n, wr_n, bus_req, level, a);
    end
    stop_play();
  endtask

  initial begin
    test_reset();
    test_mono();
    test_stereo();
    test_grant();
    test_underrun();
    test_full();
    test_reset_mid_strobe();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
